// File: rtl/imem_load_controller_pkg.sv
// Shared types and constants for the instruction-memory load controller.
// FSM encoding, the NOP word and byte-assembly helpers live here.
package imem_load_controller_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StWrite,
    StFlush,
    StRestart
  } state_e;

  localparam logic [31:0] NOP = 32'h0000_0000;

  // Counts 0..4 bytes of the word being assembled.
  localparam int unsigned BYTE_CNT_W = 3;

  typedef logic [BYTE_CNT_W-1:0] byte_cnt_t;

  // Move the n most recent bytes to the top of the word and zero-fill the rest.
  function automatic logic [31:0] left_justify(input logic [31:0] shift, input byte_cnt_t n);
    logic [31:0] w_res;
    case (n)
      byte_cnt_t'(1): w_res = {shift[7:0], 24'h0};
      byte_cnt_t'(2): w_res = {shift[15:0], 16'h0};
      byte_cnt_t'(3): w_res = {shift[23:0], 8'h0};
      default:        w_res = shift;
    endcase
    return w_res;
  endfunction

endpackage

// File: rtl/imem_load_controller_word_assembler.sv
// Packs UART bytes into big-endian 32-bit words and tracks rx inactivity.
// Enables come from the controller FSM; this block holds no state machine.
module imem_load_controller_word_assembler
  import imem_load_controller_pkg::*;
#(
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic        i_active,
  input  logic        i_accept,
  input  logic        i_word_done,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  output logic [31:0] o_word,
  output logic [31:0] o_partial_word,
  output logic        o_word_ready,
  output logic        o_partial_valid,
  output logic        o_timeout
);

  localparam int unsigned TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [31:0]     r_shift, w_shift_next;
  byte_cnt_t       r_byte_cnt, w_byte_cnt_next, w_byte_base;
  logic [TO_W-1:0] r_timeout_cnt, w_timeout_next;

  // A word completed in the WRITE cycle restarts counting, so a byte landing
  // there becomes byte 0 of the next word.
  assign w_byte_base = i_word_done ? '0 : r_byte_cnt;

  always_comb begin
    w_shift_next    = r_shift;
    w_byte_cnt_next = r_byte_cnt;
    w_timeout_next  = r_timeout_cnt;
    if (i_clear) begin
      w_shift_next    = '0;
      w_byte_cnt_next = '0;
      w_timeout_next  = '0;
    end else begin
      if (i_word_done) begin
        w_byte_cnt_next = '0;
      end
      if (i_accept && i_rx_valid) begin
        w_shift_next    = {r_shift[23:0], i_rx_data};
        w_byte_cnt_next = w_byte_base + byte_cnt_t'(1);
      end
      if (i_active) begin
        if (i_rx_valid) begin
          w_timeout_next = '0;
        end else if (r_timeout_cnt != TO_LAST) begin
          w_timeout_next = r_timeout_cnt + TO_W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift       <= '0;
      r_byte_cnt    <= '0;
      r_timeout_cnt <= '0;
    end else begin
      r_shift       <= w_shift_next;
      r_byte_cnt    <= w_byte_cnt_next;
      r_timeout_cnt <= w_timeout_next;
    end
  end

  assign o_word          = r_shift;
  assign o_partial_word  = left_justify(r_shift, r_byte_cnt);
  assign o_word_ready    = i_accept && i_rx_valid && !i_word_done
                           && (r_byte_cnt == byte_cnt_t'(3));
  assign o_partial_valid = (r_byte_cnt != '0);
  assign o_timeout       = (r_timeout_cnt == TO_LAST) && !i_rx_valid;

endmodule

// File: rtl/imem_load_controller.sv
// Shares the instruction memory port between CPU fetch and a UART program load,
// holding the pipeline on NOP during the load and pulsing restart at the end.
module imem_load_controller
  import imem_load_controller_pkg::*;
#(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load_start,
  input  logic              i_load_end,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  input  logic [31:0]       i_cpu_pc,
  output logic [31:0]       o_cpu_instruction,
  output logic              o_cpu_no_op,
  output logic              o_cpu_restart,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata,
  output logic              o_load_busy,
  output logic [ADDR_W:0]   o_loaded_words,
  output logic              o_load_overflow
);

  localparam int unsigned LW = ADDR_W + 1;

  state_e            r_state, w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [LW-1:0]     r_loaded_words;
  logic              r_overflow;

  logic        w_idle, w_collect, w_write, w_full;
  logic        w_clear, w_active, w_accept, w_inc, w_ovf_set;
  logic        w_mem_we;
  logic [31:0] w_mem_wdata, w_word, w_partial_word;
  logic        w_word_ready, w_partial_valid, w_timeout;
  logic        w_unused_pc;

  assign w_idle    = (r_state == StIdle);
  assign w_collect = (r_state == StCollect);
  assign w_write   = (r_state == StWrite);
  // loaded_words never exceeds 2**ADDR_W, so its top bit alone marks full.
  assign w_full    = r_loaded_words[ADDR_W];

  assign w_clear   = w_idle && i_load_start;
  assign w_active  = w_collect || w_write;
  // load_end wins over a same-cycle byte; a full memory swallows bytes.
  assign w_accept  = (w_collect && !i_load_end && !w_full) || w_write;
  assign w_ovf_set = w_collect && i_rx_valid && w_full;

  imem_load_controller_word_assembler #(
    .TIMEOUT (TIMEOUT)
  ) u_word_assembler (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_clear         (w_clear),
    .i_active        (w_active),
    .i_accept        (w_accept),
    .i_word_done     (w_write),
    .i_rx_valid      (i_rx_valid),
    .i_rx_data       (i_rx_data),
    .o_word          (w_word),
    .o_partial_word  (w_partial_word),
    .o_word_ready    (w_word_ready),
    .o_partial_valid (w_partial_valid),
    .o_timeout       (w_timeout)
  );

  always_comb begin
    w_state_next = r_state;
    w_mem_we     = 1'b0;
    w_mem_wdata  = NOP;
    w_inc        = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_load_start) begin
          w_state_next = StCollect;
        end
      end
      StCollect: begin
        if (i_load_end || w_timeout) begin
          w_state_next = StFlush;
        end else if (w_word_ready) begin
          w_state_next = StWrite;
        end
      end
      StWrite: begin
        if (!w_full) begin
          w_mem_we    = 1'b1;
          w_mem_wdata = w_word;
          w_inc       = 1'b1;
        end
        w_state_next = StCollect;
      end
      StFlush: begin
        if (w_partial_valid && !w_full) begin
          w_mem_we    = 1'b1;
          w_mem_wdata = w_partial_word;
          w_inc       = 1'b1;
        end
        w_state_next = StRestart;
      end
      StRestart: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= StIdle;
      r_addr         <= '0;
      r_loaded_words <= '0;
      r_overflow     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_clear) begin
        r_addr         <= '0;
        r_loaded_words <= '0;
        r_overflow     <= 1'b0;
      end else begin
        if (w_inc) begin
          r_addr         <= r_addr + ADDR_W'(1);
          r_loaded_words <= r_loaded_words + LW'(1);
        end
        if (w_ovf_set) begin
          r_overflow <= 1'b1;
        end
      end
    end
  end

  assign o_mem_addr        = w_idle ? i_cpu_pc[ADDR_W+1:2] : r_addr;
  assign o_cpu_instruction = w_idle ? i_mem_rdata : NOP;
  assign o_cpu_no_op       = !w_idle;
  assign o_cpu_restart     = (r_state == StRestart);
  assign o_load_busy       = !w_idle;
  assign o_mem_we          = w_mem_we;
  assign o_mem_wdata       = w_mem_wdata;
  assign o_loaded_words    = r_loaded_words;
  assign o_load_overflow   = r_overflow;

  // Byte offset and bits above the memory range play no part in fetch.
  assign w_unused_pc = ^{i_cpu_pc[31:ADDR_W+2], i_cpu_pc[1:0]};

endmodule
